boreal_ledger_arb: RTL and testbench

Arbiter and sequencer for the single append port of `boreal_ledger`. It shares that port between `N_REQ` requesters with a round-robin policy and issues exactly one `wr_en` pulse per accepted entry. It then confirms the commit by watching the ledger's `idx` advance, and reports the committed slot back to the requester. It sits between the producer blocks and `boreal_ledger`, and is the only driver of the ledger's `wr_en`/`wr_data`.

---
 rtl/boreal_ledger_pkg.sv | 20 ++
 rtl/boreal_rr_arbiter.sv | 43 ++++
 rtl/boreal_ledger_arb.sv | 199 +++++++++++++++++++
 tb/tb_boreal_ledger_arb.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_ledger_pkg.sv
// Shared types and constants for the boreal ledger append-port arbiter.
//   arb_state_t    : arbiter FSM state encoding
//   LEDGER_ENTRY_W : ledger entry width (bits)
//   LEDGER_IDX_W   : ledger index width (bits)
//   ARB_TAG_W      : width of the requester tag field used when
//                    BOREAL_LEDGER_ARB_TAG_EN is defined
package boreal_ledger_pkg;

    localparam int LEDGER_ENTRY_W = 256;
    localparam int LEDGER_IDX_W   = 32;
    localparam int ARB_TAG_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CONFIRM = 2'd2,
        FAULT   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/boreal_rr_arbiter.sv
// N-way combinational round-robin pick.
// Ports:
//   req   [N]     : request vector
//   ptr   [PTR_W] : highest-priority requester this round (0..N-1)
//   grant [N]     : one-hot grant of the first requester at or after ptr
//   any           : at least one request is present
module boreal_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any
);

    logic [PTR_W:0]   pos;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        pos   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            // Walk the requesters starting at ptr, wrapping modulo N
            // (N need not be a power of two).
            pos = {1'b0, ptr} + (PTR_W+1)'(off);
            if (pos >= (PTR_W+1)'(N)) begin
                pos = pos - (PTR_W+1)'(N);
            end
            idx = pos[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/boreal_ledger_arb.sv
// Round-robin arbiter and sequencer for the single append port of
// boreal_ledger. Issues one wr_en per accepted entry, confirms the commit
// by watching the ledger idx advance, and reports the committed slot.
//
// Optional build macro: BOREAL_LEDGER_ARB_TAG_EN
//   When defined, the top ARB_TAG_W bits of led_wr_data carry the
//   zero-extended requester id instead of the entry's own bits.
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   req_valid[N]   : requester i has an entry pending
//   req_data       : entry of requester i in [i*ENTRY_W +: ENTRY_W]
//   req_ready[N]   : one-hot one-cycle accept pulse
//   pause          : blocks new grants (in-flight entry still completes)
//   led_wr_en      : ledger write strobe
//   led_wr_data    : ledger write data
//   led_idx        : ledger current index
//   commit_valid   : one-cycle pulse when an entry is confirmed
//   commit_id      : requester whose entry committed
//   commit_idx     : ledger slot the entry occupies
//   busy           : FSM is not IDLE
//   fault          : sticky; ledger failed to advance within TIMEOUT cycles
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an unpaused request; grants and captures winner
// ISSUE   | drives the one-cycle write, latches expected next idx
// CONFIRM | waits for led_idx to reach the expected value, or times out
// FAULT   | ledger did not advance; frozen until reset
module boreal_ledger_arb
    import boreal_ledger_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ENTRY_W = LEDGER_ENTRY_W,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ENTRY_W-1:0]  req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      pause,
    output logic                      led_wr_en,
    output logic [ENTRY_W-1:0]        led_wr_data,
    input  logic [LEDGER_IDX_W-1:0]   led_idx,
    output logic                      commit_valid,
    output logic [$clog2(N_REQ)-1:0]  commit_id,
    output logic [LEDGER_IDX_W-1:0]   commit_idx,
    output logic                      busy,
    output logic                      fault
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMO_W = 8;

    arb_state_t                state, state_nxt;
    logic [ID_W-1:0]           rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]           win_id, win_id_nxt;
    logic [ENTRY_W-1:0]        win_data, win_data_nxt;
    logic [LEDGER_IDX_W-1:0]   exp_idx, exp_idx_nxt;
    logic [TMO_W-1:0]          tmo_cnt, tmo_cnt_nxt;

    logic [N_REQ-1:0]          req_ready_nxt;
    logic                      wr_en_nxt;
    logic [ENTRY_W-1:0]        wr_data_nxt;
    logic                      commit_valid_nxt;
    logic [ID_W-1:0]           commit_id_nxt;
    logic [LEDGER_IDX_W-1:0]   commit_idx_nxt;

    logic [N_REQ-1:0]          grant;
    logic                      grant_any;
    logic [ID_W-1:0]           grant_id;
    logic [ENTRY_W-1:0]        grant_data;
    logic [ENTRY_W-1:0]        issue_data;

    boreal_rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (grant_any)
    );

    always_comb begin
        grant_id   = '0;
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id   = ID_W'(i);
                grant_data = req_data[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

`ifdef BOREAL_LEDGER_ARB_TAG_EN
    assign issue_data = {ARB_TAG_W'(win_id), win_data[ENTRY_W-ARB_TAG_W-1:0]};
`else
    assign issue_data = win_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        rr_ptr_nxt       = rr_ptr;
        win_id_nxt       = win_id;
        win_data_nxt     = win_data;
        exp_idx_nxt      = exp_idx;
        tmo_cnt_nxt      = tmo_cnt;
        req_ready_nxt    = '0;
        wr_en_nxt        = 1'b0;
        wr_data_nxt      = '0;
        commit_valid_nxt = 1'b0;
        commit_id_nxt    = commit_id;
        commit_idx_nxt   = commit_idx;

        case (state)
            IDLE: begin
                if (!pause && grant_any) begin
                    req_ready_nxt = grant;
                    win_id_nxt    = grant_id;
                    win_data_nxt  = grant_data;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                wr_en_nxt   = 1'b1;
                wr_data_nxt = issue_data;
                exp_idx_nxt = led_idx + LEDGER_IDX_W'(1);
                tmo_cnt_nxt = '0;
                state_nxt   = CONFIRM;
            end
            CONFIRM: begin
                if (led_idx == exp_idx) begin
                    commit_valid_nxt = 1'b1;
                    commit_id_nxt    = win_id;
                    commit_idx_nxt   = exp_idx - LEDGER_IDX_W'(1);
                    rr_ptr_nxt       = (win_id == ID_W'(N_REQ-1)) ? '0
                                                                  : win_id + ID_W'(1);
                    state_nxt        = IDLE;
                end else if (tmo_cnt + TMO_W'(1) == TMO_W'(TIMEOUT)) begin
                    // This is the TIMEOUT-th CONFIRM cycle without progress.
                    state_nxt = FAULT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            win_id       <= '0;
            win_data     <= '0;
            exp_idx      <= '0;
            tmo_cnt      <= '0;
            req_ready    <= '0;
            led_wr_en    <= 1'b0;
            led_wr_data  <= '0;
            commit_valid <= 1'b0;
            commit_id    <= '0;
            commit_idx   <= '0;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            rr_ptr       <= rr_ptr_nxt;
            win_id       <= win_id_nxt;
            win_data     <= win_data_nxt;
            exp_idx      <= exp_idx_nxt;
            tmo_cnt      <= tmo_cnt_nxt;
            req_ready    <= req_ready_nxt;
            led_wr_en    <= wr_en_nxt;
            led_wr_data  <= wr_data_nxt;
            commit_valid <= commit_valid_nxt;
            commit_id    <= commit_id_nxt;
            commit_idx   <= commit_idx_nxt;
            busy         <= (state_nxt != IDLE);
            fault        <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_boreal_ledger_arb.sv
// Testbench for boreal_ledger_arb: a behavioural ledger with configurable
// idx latency drives led_idx, and a round-robin reference predicts grants.
module tb_boreal_ledger_arb;

    localparam int N_REQ   = 4;
    localparam int ENTRY_W = 256;
    localparam int TIMEOUT = 15;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ*ENTRY_W-1:0] req_data = '0;
    logic [N_REQ-1:0]         req_ready;
    logic                     pause = 1'b0;
    logic                     led_wr_en;
    logic [ENTRY_W-1:0]       led_wr_data;
    logic [31:0]              led_idx = '0;
    logic                     commit_valid;
    logic [1:0]               commit_id;
    logic [31:0]              commit_idx;
    logic                     busy;
    logic                     fault;

    int checks = 0;
    int failures = 0;
    int model_ptr = 0;
    int cyc = 0;

    // ledger model controls
    bit          idx_load = 1'b0;
    logic [31:0] idx_load_val = '0;
    bit          ledger_hold = 1'b0;
    int          k_lat = 1;
    int          lat_cnt = 0;

    // monitors
    int n_rdy = 0, n_wr = 0, n_cv = 0, wr_double = 0;
    bit prev_wr = 1'b0;

    boreal_ledger_arb #(
        .N_REQ   (N_REQ),
        .ENTRY_W (ENTRY_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .pause        (pause),
        .led_wr_en    (led_wr_en),
        .led_wr_data  (led_wr_data),
        .led_idx      (led_idx),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_idx   (commit_idx),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ledger: idx advances k_lat cycles after a sampled wr_en (k_lat=1 means
    // the new idx is visible the cycle after the write).
    always @(posedge clk) begin
        if (idx_load) begin
            led_idx <= idx_load_val;
            lat_cnt = 0;
        end else begin
            if (lat_cnt > 0) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) led_idx <= led_idx + 32'd1;
            end
            if (led_wr_en && !ledger_hold) begin
                if (k_lat <= 1) led_idx <= led_idx + 32'd1;
                else lat_cnt = k_lat - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (req_ready != '0) n_rdy = n_rdy + 1;
        if (led_wr_en) n_wr = n_wr + 1;
        if (commit_valid) n_cv = n_cv + 1;
        if (led_wr_en && prev_wr) wr_double = wr_double + 1;
        prev_wr = led_wr_en;
    end

    function automatic int rr_pick(input logic [N_REQ-1:0] vmask, input int ptr);
        for (int off = 0; off < N_REQ; off++) begin
            if (vmask[(ptr + off) % N_REQ]) return (ptr + off) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [ENTRY_W-1:0] exp_entry(input int id);
        logic [ENTRY_W-1:0] d;
        d = req_data[id*ENTRY_W +: ENTRY_W];
`ifdef BOREAL_LEDGER_ARB_TAG_EN
        d[ENTRY_W-1 -: 8] = 8'(id);
`endif
        return d;
    endfunction

    task automatic fill_data();
        for (int r = 0; r < N_REQ; r++)
            for (int w = 0; w < ENTRY_W/32; w++)
                req_data[r*ENTRY_W + w*32 +: 32] = $urandom();
    endtask

    task automatic set_idx(input logic [31:0] v);
        @(negedge clk);
        idx_load_val = v;
        idx_load = 1'b1;
        @(negedge clk);
        idx_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        pause = 1'b0;
        ledger_hold = 1'b0;
        k_lat = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
    endtask

    // which: 0 req_ready, 1 led_wr_en, 2 commit_valid, 3 fault
    task automatic wait_sig(input int which, input int budget, output int gap);
        gap = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((which == 0 && req_ready != '0) || (which == 1 && led_wr_en) ||
                (which == 2 && commit_valid) || (which == 3 && fault)) begin
                gap = i;
                break;
            end
        end
    endtask

    task automatic run_txn(input logic [N_REQ-1:0] vmask, input bit hold_valid,
                           output logic [N_REQ-1:0] rdy, output logic [ENTRY_W-1:0] wdata,
                           output int wr_gap, output int cm_gap, output logic [1:0] cid,
                           output logic [31:0] cidx, output int acc_cyc, output bit tmo);
        int g;
        tmo = 1'b0; rdy = '0; wdata = '0; wr_gap = -1; cm_gap = -1;
        cid = '0; cidx = '0; acc_cyc = -1;
        req_valid = vmask;
        wait_sig(0, 30, g);
        if (g < 0) begin
            tmo = 1'b1;
            req_valid = '0;
            return;
        end
        rdy = req_ready;
        acc_cyc = cyc;
        if (!hold_valid) req_valid = '0;
        wait_sig(1, 10, wr_gap);
        if (wr_gap < 0) begin
            tmo = 1'b1;
            return;
        end
        wdata = led_wr_data;
        wait_sig(2, 30, cm_gap);
        if (cm_gap < 0) begin
            tmo = 1'b1;
            return;
        end
        cid = commit_id;
        cidx = commit_idx;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (led_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", led_wr_en); end
        checks++; if (led_wr_data !== '0) begin failures++; $display("FAIL reset_wr_data: got %h expected 0", led_wr_data); end
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit_valid: got %b expected 0", commit_valid); end
        checks++; if (commit_id !== 2'd0) begin failures++; $display("FAIL reset_commit_id: got %0d expected 0", commit_id); end
        checks++; if (commit_idx !== 32'd0) begin failures++; $display("FAIL reset_commit_idx: got %h expected 0", commit_idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", fault); end
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] rdy; logic [ENTRY_W-1:0] wd; int wg, cg, ac; logic [1:0] cid;
        logic [31:0] cidx; bit tmo; int r0, w0;
        do_reset();
        set_idx(32'd7);
        req_data[2*ENTRY_W +: ENTRY_W] = {(ENTRY_W/8){8'hA5}};
        r0 = n_rdy; w0 = n_wr;
        run_txn(4'b0100, 1'b0, rdy, wd, wg, cg, cid, cidx, ac, tmo);
        repeat (8) @(negedge clk);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL single_timeout: got %b expected 0", tmo); end
        checks++; if (rdy !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b expected 0100", rdy); end
        checks++; if (wd !== exp_entry(2)) begin failures++; $display("FAIL single_wr_data: got %h expected %h", wd, exp_entry(2)); end
        checks++; if (wg !== 1) begin failures++; $display("FAIL single_wr_latency: got %0d expected 1", wg); end
        checks++; if (cg !== 2) begin failures++; $display("FAIL single_commit_latency: got %0d expected 2", cg); end
        checks++; if (cid !== 2'd2) begin failures++; $display("FAIL single_commit_id: got %0d expected 2", cid); end
        checks++; if (cidx !== 32'd7) begin failures++; $display("FAIL single_commit_idx: got %0d expected 7", cidx); end
        checks++; if (n_rdy - r0 !== 1) begin failures++; $display("FAIL single_ready_count: got %0d expected 1", n_rdy - r0); end
        checks++; if (n_wr - w0 !== 1) begin failures++; $display("FAIL single_wr_count: got %0d expected 1", n_wr - w0); end
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] rdy; logic [ENTRY_W-1:0] wd; int wg, cg, ac, prev_ac; logic [1:0] cid;
        logic [31:0] cidx, base; bit tmo; int id;
        do_reset();
        base = $urandom_range(0, 32'h7FFF_0000);
        set_idx(base);
        fill_data();
        prev_ac = 0;
        for (int t = 0; t < 5; t++) begin
            run_txn(4'hF, 1'b1, rdy, wd, wg, cg, cid, cidx, ac, tmo);
            id = t % N_REQ;
            checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL fair_timeout[%0d]: got %b expected 0", t, tmo); end
            checks++; if (rdy !== 4'(1 << id)) begin failures++; $display("FAIL fair_ready[%0d]: got %b expected %b", t, rdy, 4'(1 << id)); end
            checks++; if (cid !== 2'(id)) begin failures++; $display("FAIL fair_commit_id[%0d]: got %0d expected %0d", t, cid, id); end
            checks++; if (cidx !== base + 32'(t)) begin failures++; $display("FAIL fair_commit_idx[%0d]: got %h expected %h", t, cidx, base + 32'(t)); end
            checks++; if (wd !== exp_entry(id)) begin failures++; $display("FAIL fair_wr_data[%0d]: got %h expected %h", t, wd, exp_entry(id)); end
            if (t > 0) begin
                checks++; if (ac - prev_ac !== 4) begin failures++; $display("FAIL fair_spacing[%0d]: got %0d expected 4", t, ac - prev_ac); end
            end
            prev_ac = ac;
        end
        req_valid = '0;
        model_ptr = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] rdy, vmask; logic [ENTRY_W-1:0] wd; int wg, cg, ac, win; logic [1:0] cid;
        logic [31:0] cidx, base; bit tmo;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            vmask = 4'($urandom_range(1, 15));
            fill_data();
            k_lat = $urandom_range(1, 3);
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 1)) : $urandom();
            set_idx(base);
            win = rr_pick(vmask, model_ptr);
            run_txn(vmask, 1'b0, rdy, wd, wg, cg, cid, cidx, ac, tmo);
            checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL rand_timeout[%0d]: got %b expected 0", t, tmo); end
            checks++; if (rdy !== 4'(1 << win)) begin failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", t, rdy, 4'(1 << win)); end
            checks++; if (wd !== exp_entry(win)) begin failures++; $display("FAIL rand_wr_data[%0d]: got %h expected %h", t, wd, exp_entry(win)); end
            checks++; if (wg !== 1) begin failures++; $display("FAIL rand_wr_latency[%0d]: got %0d expected 1", t, wg); end
            checks++; if (cg !== k_lat + 1) begin failures++; $display("FAIL rand_commit_latency[%0d]: got %0d expected %0d", t, cg, k_lat + 1); end
            checks++; if (cid !== 2'(win)) begin failures++; $display("FAIL rand_commit_id[%0d]: got %0d expected %0d", t, cid, win); end
            checks++; if (cidx !== base) begin failures++; $display("FAIL rand_commit_idx[%0d]: got %h expected %h", t, cidx, base); end
            model_ptr = (win + 1) % N_REQ;
        end
        k_lat = 1;
    endtask

    task automatic test_wrap();
        logic [N_REQ-1:0] rdy; logic [ENTRY_W-1:0] wd; int wg, cg, ac; logic [1:0] cid;
        logic [31:0] cidx; bit tmo;
        do_reset();
        set_idx(32'hFFFF_FFFF);
        fill_data();
        run_txn(4'b0001, 1'b0, rdy, wd, wg, cg, cid, cidx, ac, tmo);
        @(negedge clk);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL wrap_timeout: got %b expected 0", tmo); end
        checks++; if (cidx !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_commit_idx: got %h expected ffffffff", cidx); end
        checks++; if (led_idx !== 32'd0) begin failures++; $display("FAIL wrap_ledger_idx: got %h expected 0", led_idx); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL wrap_fault: got %b expected 0", fault); end
    endtask

    task automatic test_timeout();
        int g, r0, w0, c0;
        do_reset();
        set_idx(32'd5);
        ledger_hold = 1'b1;
        req_valid = 4'b1000;
        wait_sig(0, 20, g);
        checks++; if (g < 0) begin failures++; $display("FAIL tmo_accept: got none expected req_ready"); end
        req_valid = 4'hF;
        wait_sig(1, 10, g);
        checks++; if (g !== 1) begin failures++; $display("FAIL tmo_wr_latency: got %0d expected 1", g); end
        wait_sig(3, 40, g);
        checks++; if (g !== TIMEOUT) begin failures++; $display("FAIL tmo_fault_delay: got %0d expected %0d", g, TIMEOUT); end
        r0 = n_rdy; w0 = n_wr; c0 = n_cv;
        repeat (30) @(negedge clk);
        checks++; if (n_rdy - r0 !== 0) begin failures++; $display("FAIL tmo_no_grant: got %0d expected 0", n_rdy - r0); end
        checks++; if (n_wr - w0 !== 0) begin failures++; $display("FAIL tmo_no_write: got %0d expected 0", n_wr - w0); end
        checks++; if (n_cv - c0 !== 0) begin failures++; $display("FAIL tmo_no_commit: got %0d expected 0", n_cv - c0); end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL tmo_fault_sticky: got %b expected 1", fault); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tmo_busy: got %b expected 1", busy); end
        do_reset();
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL tmo_fault_cleared: got %b expected 0", fault); end
    endtask

    task automatic test_pause();
        int g, r0;
        do_reset();
        set_idx(32'd20);
        fill_data();
        req_valid = 4'b0011;
        wait_sig(0, 20, g);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL pause_first_ready: got %b expected 0001", req_ready); end
        wait_sig(1, 10, g);
        pause = 1'b1;
        wait_sig(2, 20, g);
        checks++; if (commit_id !== 2'd0) begin failures++; $display("FAIL pause_commit_id: got %0d expected 0", commit_id); end
        checks++; if (commit_idx !== 32'd20) begin failures++; $display("FAIL pause_commit_idx: got %0d expected 20", commit_idx); end
        r0 = n_rdy;
        repeat (12) @(negedge clk);
        checks++; if (n_rdy - r0 !== 0) begin failures++; $display("FAIL pause_blocks_grant: got %0d expected 0", n_rdy - r0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pause_busy: got %b expected 0", busy); end
        pause = 1'b0;
        wait_sig(0, 20, g);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL pause_resume_ready: got %b expected 0010", req_ready); end
        req_valid = '0;
        wait_sig(2, 20, g);
        checks++; if (commit_idx !== 32'd21) begin failures++; $display("FAIL pause_resume_idx: got %0d expected 21", commit_idx); end
        model_ptr = 2;
    endtask

    task automatic test_reset_mid();
        logic [N_REQ-1:0] rdy; logic [ENTRY_W-1:0] wd; int wg, cg, ac, g, w0, c0; logic [1:0] cid;
        logic [31:0] cidx; bit tmo;
        do_reset();
        set_idx(32'd50);
        fill_data();
        run_txn(4'b1000, 1'b0, rdy, wd, wg, cg, cid, cidx, ac, tmo);
        checks++; if (cid !== 2'd3) begin failures++; $display("FAIL mid_setup_id: got %0d expected 3", cid); end
        req_valid = 4'b0100;
        wait_sig(0, 20, g);
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL mid_req_ready: got %b expected 0", req_ready); end
        checks++; if (led_wr_en !== 1'b0) begin failures++; $display("FAIL mid_wr_en: got %b expected 0", led_wr_en); end
        checks++; if (led_wr_data !== '0) begin failures++; $display("FAIL mid_wr_data: got %h expected 0", led_wr_data); end
        checks++; if (commit_id !== 2'd0) begin failures++; $display("FAIL mid_commit_id: got %0d expected 0", commit_id); end
        checks++; if (commit_idx !== 32'd0) begin failures++; $display("FAIL mid_commit_idx: got %h expected 0", commit_idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        w0 = n_wr; c0 = n_cv;
        repeat (15) @(negedge clk);
        checks++; if (n_cv - c0 !== 0) begin failures++; $display("FAIL mid_no_commit: got %0d expected 0", n_cv - c0); end
        checks++; if (n_wr - w0 !== 0) begin failures++; $display("FAIL mid_no_write: got %0d expected 0", n_wr - w0); end
        checks++; if (led_idx !== 32'd51) begin failures++; $display("FAIL mid_ledger_idx: got %0d expected 51", led_idx); end
        model_ptr = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_random();
        test_wrap();
        test_pause();
        test_timeout();
        test_reset_mid();
        checks++; if (wr_double !== 0) begin failures++; $display("FAIL wr_en_back_to_back: got %0d expected 0", wr_double); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
